regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-port arbiter and scoreboard for the 32x32 synchronous register file, which has one write port, writes on negedge and hard-wires r0 to zero. Two writers share the port: the in-order pipeline writeback and a long-latency unit (mul/div), whose results sit in a small FIFO. Tracks destinations pending from the long-latency unit and raises a read-hazard stall. Sits between the WB stage / long-latency unit and the register file write port.

Parameters:
LU_FIFO_DEPTH, 2, long-latency result FIFO entries (power of 2, >=2)
STARVE_MAX, 4, consecutive cycles a non-empty FIFO may lose arbitration before pipe_hold asserts (>=1)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  global enable; 0 freezes all state
pipe_w_en  in  1  pipeline WB write request
pipe_rd  in  5  pipeline WB destination
pipe_data  in  32  pipeline WB data
lu_issue  in  1  long-latency op issued; marks lu_issue_rd pending
lu_issue_rd  in  5  destination of issued long-latency op
lu_valid  in  1  long-latency result valid
lu_rd  in  5  result destination
lu_data  in  32  result data
lu_ready  out  1  FIFO can accept; = en & !full
chk_a  in  5  decode read-port A index
chk_b  in  5  decode read-port B index
stall  out  1  combinational read hazard
pipe_hold  out  1  pipeline must not present pipe_w_en this cycle
rf_w_en  out  1  register file write enable (registered)
rf_req_w  out  5  register file write index (registered)
rf_data_w  out  32  register file write data (registered)
err  out  1  sticky protocol-violation flag

Behaviour:
- Clock is clk; reset is asynchronous, active-low rst_n.
- Reset: rf_w_en=0, rf_req_w=0, rf_data_w=0, err=0, pending[31:1]=0, FIFO empty, starve counter=0. pipe_hold=0. lu_ready=en.
- Valid requests: pipe valid = pipe_w_en & pipe_rd!=0. FIFO push = lu_valid & lu_ready. lu_rd==0 entries are pushed and later popped, but never write.
- Arbitration, evaluated each posedge with en=1:
  - pipe_hold=0: a valid pipe request wins; otherwise the FIFO head wins.
  - pipe_hold=1: the FIFO head wins.
- Output latency: the winner's index and data are registered onto rf_*, with rf_w_en=1 for a nonzero index. The register file commits at the following negedge, so a write presented at posedge N is readable after negedge N.
- No winner: rf_w_en=0 and rf_req_w/rf_data_w hold their values.
- FIFO: pop occurs when the head wins. Push and pop in the same cycle are allowed. lu_ready ignores a same-cycle pop (no full bypass). Pointers wrap modulo LU_FIFO_DEPTH.
- Starve counter:
  - Increments when the FIFO is non-empty and the pipe wins.
  - Clears on pop or when the FIFO is empty.
  - pipe_hold = (counter == STARVE_MAX) & !empty, combinational.
- Scoreboard:
  - pending[lu_issue_rd] is set on lu_issue with a nonzero rd.
  - pending[rd] is cleared when a FIFO pop for that rd is granted.
  - Set and clear of the same index in the same cycle: set wins.
- stall = (chk_a!=0 & pending[chk_a]) | (chk_b!=0 & pending[chk_b]). r0 never stalls.
- err sets and stays set until reset on any of:
  - lu_issue to an rd that is already pending;
  - push with a nonzero lu_rd that is not pending;
  - valid pipe request to a pending rd (WAW);
  - pipe_w_en while pipe_hold=1. The pipe write is dropped and the FIFO wins.
- en=0: no state change, rf_w_en forced 0 at the next posedge, lu_ready=0, and lu_issue/pipe inputs are ignored.
- Reset mid-operation clears the FIFO and scoreboard immediately and discards in-flight results. rf_w_en drops asynchronously.

Test Plan:
- Reset, then pipe_w_en=1, pipe_rd=5, data=0xDEADBEEF for 1 cycle -> next posedge rf_w_en=1, rf_req_w=5, rf_data_w=0xDEADBEEF; following cycle rf_w_en=0; err=0.
- lu_issue rd=7; chk_a=7 -> stall=1. lu_valid rd=7, data=0x12 with the pipe idle -> rf write of r7=0x12 one cycle after the push; stall falls the cycle after the pop. chk_a=0 never stalls.
- Pipe writes every cycle while 1 result is queued (STARVE_MAX=4) -> pipe wins 4 cycles, pipe_hold=1 on the 5th; the FIFO entry writes that cycle; pipe_hold=0 next.
- Two lu results pushed back-to-back (depth 2) -> lu_ready=0 while full, rises after the first pop; writes drain in order.
- lu_issue rd=3 twice -> err=1 and remains 1. Pipe write to pending r3 -> err. pipe_w_en during pipe_hold -> pipe write dropped, err=1.
- Assert rst_n=0 with 2 entries queued and 3 rd pending -> immediately rf_w_en=0, stall=0, lu_ready=en, err=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued long-latency results,
// with a pending-destination scoreboard that drives the decode read-hazard stall.
module regfile_wb_arbiter #(
    parameter int LU_FIFO_DEPTH = 2,
    parameter int STARVE_MAX    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pipe_w_en,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_rd,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  chk_a,
    input  logic [4:0]  chk_b,
    output logic        stall,
    output logic        pipe_hold,
    output logic        rf_w_en,
    output logic [4:0]  rf_req_w,
    output logic [31:0] rf_data_w,
    output logic        err
);

    localparam int PTR_W = (LU_FIFO_DEPTH > 1) ? $clog2(LU_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [4:0]       fifo_rd_r   [LU_FIFO_DEPTH];
    logic [31:0]      fifo_data_r [LU_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [STV_W-1:0] starve_r;
    logic [31:1]      pending_r;
    logic             err_r;

    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             pipe_valid_s;
    logic             pipe_win_s;
    logic [4:0]       head_rd_s;
    logic [31:0]      head_data_s;
    logic [31:0]      pend_full_s;
    logic [31:0]      clr_mask_s;
    logic [31:0]      set_mask_s;
    logic [31:0]      pend_nxt_s;
    logic             err_set_s;

    assign empty_s      = (count_r == {CNT_W{1'b0}});
    assign full_s       = (count_r == CNT_W'(LU_FIFO_DEPTH));
    assign head_rd_s    = fifo_rd_r[rd_ptr_r];
    assign head_data_s  = fifo_data_r[rd_ptr_r];

    // The queue gets a guaranteed slot once it has lost STARVE_MAX times in a row.
    assign pipe_hold    = (starve_r == STV_W'(STARVE_MAX)) && !empty_s;
    assign lu_ready     = en && !full_s;
    assign push_s       = lu_valid && lu_ready;
    assign pipe_valid_s = en && pipe_w_en && (pipe_rd != 5'd0);
    assign pipe_win_s   = pipe_valid_s && !pipe_hold;
    assign pop_s        = en && !pipe_win_s && !empty_s;

    // Bit 0 of the expanded view is r0 and is never pending.
    assign pend_full_s  = {pending_r, 1'b0};
    assign clr_mask_s   = (pop_s && (head_rd_s != 5'd0)) ? (32'd1 << head_rd_s) : 32'd0;
    assign set_mask_s   = (en && lu_issue && (lu_issue_rd != 5'd0)) ? (32'd1 << lu_issue_rd) : 32'd0;
    assign pend_nxt_s   = (pend_full_s & ~clr_mask_s) | set_mask_s;

    assign stall = ((chk_a != 5'd0) && pend_full_s[chk_a]) ||
                   ((chk_b != 5'd0) && pend_full_s[chk_b]);

    assign err_set_s = en && (
        (lu_issue && (lu_issue_rd != 5'd0) && pend_full_s[lu_issue_rd]) ||
        (push_s && (lu_rd != 5'd0) && !pend_full_s[lu_rd]) ||
        (pipe_valid_s && pend_full_s[pipe_rd]) ||
        (pipe_w_en && pipe_hold));

    assign err = err_r;

    // Result FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LU_FIFO_DEPTH; i++) begin
                fifo_rd_r[i]   <= 5'd0;
                fifo_data_r[i] <= 32'd0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_rd_r[wr_ptr_r]   <= lu_rd;
                fifo_data_r[wr_ptr_r] <= lu_data;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // FIFO occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation counter: consecutive losses of a non-empty queue to the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_r <= {STV_W{1'b0}};
        end else if (!en) begin
            starve_r <= starve_r;
        end else if (pop_s || empty_s) begin
            starve_r <= {STV_W{1'b0}};
        end else if (pipe_win_s) begin
            starve_r <= starve_r + STV_W'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    // Scoreboard of destinations still owed by the long-latency unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 31'd0;
        end else begin
            pending_r <= pend_nxt_s[31:1];
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Registered write port; a winning r0 entry is consumed without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_w_en   <= 1'b0;
            rf_req_w  <= 5'd0;
            rf_data_w <= 32'd0;
        end else if (pipe_win_s) begin
            rf_w_en   <= 1'b1;
            rf_req_w  <= pipe_rd;
            rf_data_w <= pipe_data;
        end else if (pop_s) begin
            rf_w_en   <= (head_rd_s != 5'd0);
            rf_req_w  <= head_rd_s;
            rf_data_w <= head_data_s;
        end else begin
            rf_w_en   <= 1'b0;
            rf_req_w  <= rf_req_w;
            rf_data_w <= rf_data_w;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts each
// register-file write; a monitor compares every write the DUT presents.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int SM    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        pipe_w_en = 1'b0;
    logic [4:0]  pipe_rd = 5'd0;
    logic [31:0] pipe_data = 32'd0;
    logic        lu_issue = 1'b0;
    logic [4:0]  lu_issue_rd = 5'd0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rd = 5'd0;
    logic [31:0] lu_data = 32'd0;
    logic        lu_ready;
    logic [4:0]  chk_a = 5'd0;
    logic [4:0]  chk_b = 5'd0;
    logic        stall;
    logic        pipe_hold;
    logic        rf_w_en;
    logic [4:0]  rf_req_w;
    logic [31:0] rf_data_w;
    logic        err;

    regfile_wb_arbiter #(.LU_FIFO_DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .pipe_w_en(pipe_w_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .chk_a(chk_a), .chk_b(chk_b), .stall(stall), .pipe_hold(pipe_hold),
        .rf_w_en(rf_w_en), .rf_req_w(rf_req_w), .rf_data_w(rf_data_w), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wr_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } lu_t;

    wr_t         exp_q[$];
    lu_t         fifo_q[$];
    logic [4:0]  out_q[$];
    logic [31:0] m_pend = 32'd0;
    int          m_starve = 0;
    logic        m_err = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit hold_pred();
        return (m_starve == SM) && (fifo_q.size() != 0);
    endfunction

    function automatic logic [4:0] pick_free();
        logic [4:0] r;
        for (int k = 0; k < 64; k++) begin
            r = 5'($urandom_range(1, 31));
            if (!m_pend[r]) return r;
        end
        return 5'd0;
    endfunction

    // Reference model: applies the arbitration rules for the coming posedge.
    task automatic model_step();
        bit  hold, pv, push, pipe_win, pop, empty0;
        lu_t h;
        hold = hold_pred();
        check("lu_ready", lu_ready, en && (fifo_q.size() < DEPTH));
        check("pipe_hold", pipe_hold, hold);
        check("stall", stall, ((chk_a != 0) && m_pend[chk_a]) || ((chk_b != 0) && m_pend[chk_b]));
        check("err", err, m_err);
        if (!en) return;
        empty0   = (fifo_q.size() == 0);
        pv       = pipe_w_en && (pipe_rd != 0);
        push     = lu_valid && (fifo_q.size() < DEPTH);
        pipe_win = pv && !hold;
        pop      = !pipe_win && !empty0;
        if (lu_issue && lu_issue_rd != 0 && m_pend[lu_issue_rd]) m_err = 1'b1;
        if (push && lu_rd != 0 && !m_pend[lu_rd]) m_err = 1'b1;
        if (pv && m_pend[pipe_rd]) m_err = 1'b1;
        if (pipe_w_en && hold) m_err = 1'b1;
        if (pipe_win) begin
            exp_q.push_back('{cyc + 1, pipe_rd, pipe_data});
        end else if (pop) begin
            h = fifo_q.pop_front();
            if (h.rd != 0) begin
                exp_q.push_back('{cyc + 1, h.rd, h.data});
                m_pend[h.rd] = 1'b0;
            end
        end
        if (pop || empty0) m_starve = 0;
        else if (pipe_win) m_starve++;
        if (lu_issue && lu_issue_rd != 0) m_pend[lu_issue_rd] = 1'b1;
        if (push) fifo_q.push_back('{lu_rd, lu_data});
    endtask

    task automatic drive(input logic e, input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                         input logic li, input logic [4:0] lird,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic [4:0] ca, input logic [4:0] cb);
        @(negedge clk);
        en = e; pipe_w_en = pw; pipe_rd = prd; pipe_data = pd;
        lu_issue = li; lu_issue_rd = lird; lu_valid = lv; lu_rd = lrd; lu_data = ld;
        chk_a = ca; chk_b = cb;
        #1 model_step();
    endtask

    task automatic idle(input logic [4:0] ca);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, ca, 5'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b1; pipe_w_en = 1'b0; lu_issue = 1'b0; lu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rf_w_en", rf_w_en, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_lu_ready", lu_ready, en);
        check("rst_err", err, 1'b0);
        check("rst_pipe_hold", pipe_hold, 1'b0);
        fifo_q.delete(); exp_q.delete(); out_q.delete();
        m_pend = 32'd0; m_starve = 0; m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every presented write must match the oldest predicted write.
    initial forever begin
        wr_t w;
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (rf_w_en) begin
                if (exp_q.size() == 0) begin
                    check("rf_unexpected_write", {27'd0, rf_req_w}, 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("rf_cycle", 64'(cyc), 64'(w.cyc));
                    check("rf_req_w", rf_req_w, w.rd);
                    check("rf_data_w", rf_data_w, w.data);
                end
            end
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                w = exp_q.pop_front();
                check("rf_missing_write", {27'd0, rf_w_en}, 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("init_rf_w_en", rf_w_en, 1'b0);
        check("init_rf_req_w", rf_req_w, 5'd0);
        check("init_rf_data_w", rf_data_w, 32'd0);
        check("init_err", err, 1'b0);
        check("init_lu_ready", lu_ready, en);
        #11 rst_n = 1'b1;

        // Single pipeline write.
        drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle(0); idle(0);

        // Long-latency result for r7 with stall tracking.
        drive(1, 0, 0, 0, 1, 5'd7, 0, 0, 0, 5'd7, 0);
        idle(5'd7);
        drive(1, 0, 0, 0, 0, 0, 1, 5'd7, 32'h12, 5'd7, 0);
        idle(5'd7); idle(5'd7); idle(5'd0);

        // Starvation: pipeline busy while one result waits.
        drive(1, 0, 0, 0, 1, 5'd9, 0, 0, 0, 5'd9, 0);
        drive(1, 1, 5'd10, 32'hA0, 0, 0, 1, 5'd9, 32'h99, 5'd9, 0);
        for (int i = 0; i < 6; i++)
            drive(1, !hold_pred(), 5'(11 + i), $urandom, 0, 0, 0, 0, 0, 5'd9, 0);
        idle(0);

        // Fill the FIFO to depth with the pipeline busy, then drain.
        drive(1, 0, 0, 0, 1, 5'd20, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 5'd21, 0, 0, 0, 0, 0);
        drive(1, 1, 5'd1, 32'h1, 0, 0, 1, 5'd20, 32'h200, 5'd20, 5'd21);
        drive(1, 1, 5'd2, 32'h2, 0, 0, 1, 5'd21, 32'h210, 5'd20, 5'd21);
        drive(1, 1, 5'd3, 32'h3, 0, 0, 0, 0, 0, 5'd20, 5'd21);
        idle(5'd20); idle(5'd21); idle(0); idle(0);

        // en=0 freezes everything.
        drive(1, 0, 0, 0, 1, 5'd12, 0, 0, 0, 5'd12, 0);
        drive(0, 1, 5'd13, 32'h13, 1, 5'd14, 1, 5'd12, 32'hC, 5'd12, 5'd14);
        drive(1, 0, 0, 0, 0, 0, 1, 5'd12, 32'hC, 5'd12, 5'd14);
        idle(5'd12); idle(0);

        // Reset with two entries queued and three destinations pending.
        drive(1, 0, 0, 0, 1, 5'd24, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 5'd25, 0, 0, 0, 0, 0);
        drive(1, 1, 5'd1, 32'h11, 1, 5'd26, 1, 5'd24, 32'h24, 0, 0);
        drive(1, 1, 5'd2, 32'h22, 0, 0, 1, 5'd25, 32'h25, 5'd26, 5'd24);
        do_reset();

        // Randomized protocol-respecting traffic.
        for (int i = 0; i < 400; i++) begin
            logic       e, pw, li, lv, accept;
            logic [4:0] prd, lird, lrd;
            e    = ($urandom_range(0, 15) != 0);
            pw   = ($urandom_range(0, 2) != 0) && !hold_pred();
            prd  = ($urandom_range(0, 9) == 0) ? 5'd0 : pick_free();
            lird = pick_free();
            li   = ($urandom_range(0, 2) == 0) && (out_q.size() < 4) && (lird != 0);
            lv   = (out_q.size() != 0) && ($urandom_range(0, 1) != 0);
            lrd  = lv ? out_q[0] : 5'd0;
            if ($urandom_range(0, 19) == 0) begin
                lv  = 1'b1;
                lrd = 5'd0;
            end
            accept = e && (fifo_q.size() < DEPTH);
            drive(e, pw, prd, $urandom, li, lird, lv, lrd, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (lv && lrd != 0 && accept) void'(out_q.pop_front());
            if (li && e) out_q.push_back(lird);
        end
        do_reset();

        // Protocol violations, each isolated by a reset.
        drive(1, 0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0);
        idle(0); idle(0);
        do_reset();
        drive(1, 0, 0, 0, 1, 5'd3, 0, 0, 0, 0, 0);
        drive(1, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        do_reset();
        drive(1, 0, 0, 0, 1, 5'd4, 0, 0, 0, 0, 0);
        drive(1, 1, 5'd10, 32'hA, 0, 0, 1, 5'd4, 32'h44, 5'd4, 0);
        for (int i = 0; i < 6; i++)
            drive(1, 1, 5'(11 + i), $urandom, 0, 0, 0, 0, 0, 5'd4, 0);
        idle(0);
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 5'd17, 32'h17, 0, 0);
        idle(0); idle(0);
        do_reset();

        idle(0); idle(0);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
